// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package display_pkg;

  // Scan FSM: OFF (blanked), DRIVE (one digit lit), GAP (anti-ghosting dark time)
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } scan_state_e;

  // Segment pattern with every segment dark (a..g, MSB = a)
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/DisplayDecoder.sv
// Hex nibble to 7-segment pattern decoder (a..g, MSB = a, active-high).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: nibble - hex digit in; seg - segment pattern out.
module DisplayDecoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: lights one digit for PRESCALE cycles, then GAP_CYCLES dark.
// Latency: outputs registered, change in the same cycle as the FSM state; load visible at next frame start.
// Backpressure: none; load_i is a strobe, a newer load overwrites an uncommitted one.
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i scan enable; load_i/value_i value
//        capture (digit 0 in [3:0]); blank_i live per-digit blank; seg_o/dig_o segment and digit drives;
//        pending_o loaded value awaiting commit; frame_o one-cycle pulse at each frame start.
// Build option: define DISPLAY_SCAN_LZB_EN to add leading-zero blanking (digit 0 always shown).
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    pending_o,
  output logic                    frame_o
);

  localparam int PW = cnt_width(PRESCALE);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int IW = cnt_width(NUM_DIGITS);

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [GW-1:0]           gcnt_q, gcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q;
  logic                    commit;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   blank_eff;
`ifdef DISPLAY_SCAN_LZB_EN
  logic                    lz_seen;
`endif

  // Next-state: enable low always wins and clears all scan counters.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    if (!enable_i) begin
      state_d = OFF;
      pcnt_d  = '0;
      gcnt_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DRIVE;
          pcnt_d  = '0;
          idx_d   = '0;
        end
        DRIVE: begin
          if (pcnt_q == P_LAST) begin
            state_d = GAP;
            pcnt_d  = '0;
            gcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gcnt_q == G_LAST) begin
            state_d = DRIVE;
            gcnt_d  = '0;
            pcnt_d  = '0;
            idx_d   = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          pcnt_d  = '0;
          gcnt_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Commit happens only on entry into digit 0, so a frame never mixes two values.
  // A load landing on the commit edge bypasses the pending register.
  always_comb begin
    commit     = (state_d == DRIVE) && (state_q != DRIVE) && (idx_d == '0);
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (commit) begin
      if (load_i) begin
        disp_d = value_i;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (load_i) begin
      pend_d     = value_i;
      pend_vld_d = 1'b1;
    end
  end

  // The digit about to be driven, taken from the value that will be displayed.
  assign nibble = disp_d[{idx_d, 2'b00} +: 4];

  DisplayDecoder u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    blank_eff = blank_i;
`ifdef DISPLAY_SCAN_LZB_EN
    // Walk down from the top digit; dark until the first nonzero nibble, digit 0 excluded.
    lz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_seen = lz_seen | (|disp_d[4*k +: 4]);
      if (!lz_seen) begin
        blank_eff[k] = 1'b1;
      end
    end
`endif
  end

  // Outputs derived from next state so they register together with it.
  always_comb begin
    seg_d = SEG_OFF;
    dig_d = '0;
    if ((state_d == DRIVE) && !blank_eff[idx_d]) begin
      seg_d = dec_seg;
      dig_d = NUM_DIGITS'(1) << idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= OFF;
      pcnt_q     <= '0;
      gcnt_q     <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      gcnt_q     <= gcnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      frame_q    <= commit;
    end
  end

  assign seg_o     = seg_q;
  assign dig_o     = dig_q;
  assign pending_o = pend_vld_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (4 digits, 4-cycle slots, 1-cycle gap).
// Latency: n/a.
// Backpressure: n/a.
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int GC    = 1;
  localparam int SLOT  = PS + GC;
  localparam int FRAME = ND * SLOT;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [6:0]  seg_o;
  logic [3:0]  dig_o;
  logic        pending_o;
  logic        frame_o;

  int total = 0;
  int bad   = 0;

  // Reference model: time since scanning started, decoded into frame/slot/phase.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_vld;
  logic        m_frame;
  logic [6:0]  m_seg;
  logic [3:0]  m_dig;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS),
    .GAP_CYCLES (GC)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .enable_i  (enable),
    .load_i    (load),
    .value_i   (value),
    .blank_i   (blank),
    .seg_o     (seg_o),
    .dig_o     (dig_o),
    .pending_o (pending_o),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_t     = -1;
    m_disp  = '0;
    m_pend  = '0;
    m_vld   = 1'b0;
    m_frame = 1'b0;
    m_seg   = '0;
    m_dig   = '0;
  endtask

  // One clock: advance the model with the inputs present at the edge, return at the negedge.
  task automatic tick();
    int   phase;
    int   slot;
    logic dark;
    @(posedge clk);
    if (!enable) begin
      m_t     = -1;
      m_frame = 1'b0;
      m_seg   = '0;
      m_dig   = '0;
      if (load) begin
        m_pend = value;
        m_vld  = 1'b1;
      end
    end else begin
      m_t     = m_t + 1;
      phase   = m_t % FRAME;
      slot    = phase / SLOT;
      m_frame = (phase == 0);
      if (m_frame) begin
        if (load) m_disp = value;
        else if (m_vld) m_disp = m_pend;
        m_vld = 1'b0;
      end else if (load) begin
        m_pend = value;
        m_vld  = 1'b1;
      end
      dark = ((phase % SLOT) >= PS) || blank[slot];
`ifdef DISPLAY_SCAN_LZB_EN
      if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) dark = 1'b1;
`endif
      m_seg = dark ? 7'h00 : seg_tab[m_disp[4*slot +: 4]];
      m_dig = dark ? 4'h0 : 4'(1 << slot);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({seg_o, dig_o, pending_o, frame_o} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got seg=%b dig=%b pend=%b frame=%b, want all zero", seg_o, dig_o, pending_o, frame_o);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
      bad++;
      $display("FAIL reset_idle: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
    end
  endtask

  task automatic test_basic();
    load  = 1'b1;
    value = 16'h1234;
    tick();
    load = 1'b0;
    total++;
    if (pending_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_pending: got %b, want 1", pending_o);
    end
    enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL basic_cycle %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
      if (i == 0) begin
        total++;
        if ({frame_o, pending_o, dig_o, seg_o} !== {1'b1, 1'b0, 4'b0001, 7'b0110011}) begin
          bad++;
          $display("FAIL basic_first_digit: got frame=%b pend=%b dig=%b seg=%b, want 1 0 0001 0110011", frame_o, pending_o, dig_o, seg_o);
        end
      end
      if (i == 3 || i == 4) begin
        total++;
        if ({dig_o, seg_o} !== {4'b0001, 7'b0110011} && i == 3 || {dig_o, seg_o} !== 11'h0 && i == 4) begin
          bad++;
          $display("FAIL basic_slot0_edge %0d: got dig=%b seg=%b", i, dig_o, seg_o);
        end
      end
      if (i == 5) begin
        total++;
        if ({dig_o, seg_o} !== {4'b0010, 7'b1111001}) begin
          bad++;
          $display("FAIL basic_second_digit: got dig=%b seg=%b, want 0010 1111001", dig_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    load  = 1'b1;
    value = 16'hABCD;
    tick();
    load = 1'b0;
    total++;
    if (pending_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending_set: got %b, want 1", pending_o);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL mid_cycle %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
      if (m_frame) begin
        total++;
        if ({frame_o, pending_o, dig_o, seg_o} !== {1'b1, 1'b0, 4'b0001, 7'b0111101}) begin
          bad++;
          $display("FAIL mid_commit: got frame=%b pend=%b dig=%b seg=%b, want 1 0 0001 0111101", frame_o, pending_o, dig_o, seg_o);
        end
        break;
      end
    end
  endtask

  task automatic test_commit_load();
    for (int i = 0; i < FRAME; i++) begin
      if ((m_t % FRAME) == FRAME - 1) break;
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL commit_lead %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
    end
    load  = 1'b1;
    value = 16'h5555;
    tick();
    load = 1'b0;
    total++;
    if ({frame_o, pending_o, dig_o, seg_o} !== {1'b1, 1'b0, 4'b0001, 7'b1011011}) begin
      bad++;
      $display("FAIL commit_direct: got frame=%b pend=%b dig=%b seg=%b, want 1 0 0001 1011011", frame_o, pending_o, dig_o, seg_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL commit_after %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
    end
  endtask

  task automatic test_blank();
    int   last = -1;
    logic seen = 1'b0;
    blank = 4'b1000;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL blank_cycle %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
      if (dig_o === 4'b1000) seen = 1'b1;
      if (frame_o === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (i - last != FRAME) begin
            bad++;
            $display("FAIL blank_frame_period: got %0d cycles, want %0d", i - last, FRAME);
          end
        end
        last = i;
      end
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL blank_dig3: got dig_o=1000 at least once, want never");
    end
    blank = 4'b0000;
  endtask

`ifdef DISPLAY_SCAN_LZB_EN
  task automatic test_lzb();
    logic [15:0] vals [2] = '{16'h0042, 16'h0000};
    logic [6:0]  d0 [2]   = '{7'b1101101, 7'b1111110};
    logic [3:0]  dark [2] = '{4'b1100, 4'b1110};
    logic        lit;
    for (int v = 0; v < 2; v++) begin
      load  = 1'b1;
      value = vals[v];
      tick();
      load = 1'b0;
      for (int i = 0; i < FRAME + 1; i++) begin
        if (m_frame) break;
        tick();
      end
      total++;
      if ({frame_o, dig_o, seg_o} !== {1'b1, 4'b0001, d0[v]}) begin
        bad++;
        $display("FAIL lzb_digit0 %h: got frame=%b dig=%b seg=%b, want 1 0001 %b", vals[v], frame_o, dig_o, seg_o, d0[v]);
      end
      lit = 1'b0;
      for (int i = 0; i < FRAME - 1; i++) begin
        tick();
        total++;
        if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
          bad++;
          $display("FAIL lzb_cycle %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
        end
        if ((dig_o & dark[v]) !== 4'b0000) lit = 1'b1;
      end
      total++;
      if (lit) begin
        bad++;
        $display("FAIL lzb_dark %h: got a leading-zero digit lit, want dark mask %b", vals[v], dark[v]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL random_cycle %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
    end
    load   = 1'b0;
    blank  = 4'h0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) tick();
    load  = 1'b1;
    value = 16'h9876;
    tick();
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({seg_o, dig_o, pending_o, frame_o} !== 13'h0) begin
      bad++;
      $display("FAIL reset_mid_async: got seg=%b dig=%b pend=%b frame=%b, want all zero", seg_o, dig_o, pending_o, frame_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({frame_o, pending_o, dig_o, seg_o} !== {1'b1, 1'b0, 4'b0001, 7'b1111110}) begin
      bad++;
      $display("FAIL reset_mid_restart: got frame=%b pend=%b dig=%b seg=%b, want 1 0 0001 1111110", frame_o, pending_o, dig_o, seg_o);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      total++;
      if ({seg_o, dig_o, pending_o, frame_o} !== {m_seg, m_dig, m_vld, m_frame}) begin
        bad++;
        $display("FAIL reset_mid_cycle %0d: got seg=%b dig=%b pend=%b frame=%b, want %b %b %b %b", i, seg_o, dig_o, pending_o, frame_o, m_seg, m_dig, m_vld, m_frame);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    value  = '0;
    blank  = '0;
    model_reset();
    #2;
    test_reset();
    test_basic();
    test_midframe_load();
    test_commit_load();
    test_blank();
`ifdef DISPLAY_SCAN_LZB_EN
    test_lzb();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
